// File: rtl/md5_pkg.sv
// Shared constants, state type and helpers for the MD5 candidate block generator.
package md5_pkg;

    localparam logic [31:0] MD5_IV_A = 32'h67452301;
    localparam logic [31:0] MD5_IV_B = 32'hefcdab89;
    localparam logic [31:0] MD5_IV_C = 32'h98badcfe;
    localparam logic [31:0] MD5_IV_D = 32'h10325476;

    localparam int unsigned MD5_BLOCK_W      = 512;
    localparam int unsigned CHAR_W           = 8;
    localparam int unsigned MD5_MAX_LEN_1BLK = 55;

    typedef enum logic [1:0] {IDLE, RUN, DONE} md5_state_e;

    // Message length in bits, little-endian 64-bit field of the final block.
    function automatic logic [63:0] md5_len_field(input logic [5:0] len_chars);
        return {55'd0, len_chars, 3'b000};
    endfunction

endpackage

// File: rtl/md5_pad.sv
// Combinational MD5 single-block padding of a candidate held as charset digit indices.
module md5_pad
    import md5_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 8,
    parameter logic [7:0]  CHAR_BASE = 8'h61
) (
    input  logic [MAX_LEN-1:0][CHAR_W-1:0] digits_i,
    input  logic [5:0]                     len_i,
    output logic [MD5_BLOCK_W-1:0]         block_o
);

    // Characters, 0x80 terminator, zero fill, then the bit-length trailer.
    always_comb begin
        block_o = '0;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (i < int'(len_i)) begin
                block_o[8*i +: 8] = CHAR_BASE + digits_i[i];
            end
        end
        for (int i = 0; i <= int'(MD5_MAX_LEN_1BLK); i++) begin
            if (i == int'(len_i)) begin
                block_o[8*i +: 8] = 8'h80;
            end
        end
        block_o[511:448] = md5_len_field(len_i);
    end

endmodule

// File: rtl/md5_block_gen.sv
// Candidate password enumerator feeding the MD5 round pipeline with padded blocks.
// Optional feature: define MD5GEN_CAND_INDEX_EN to add the cand_index sequence output.
module md5_block_gen
    import md5_pkg::*;
#(
    parameter int unsigned MAX_LEN      = 8,
    parameter int unsigned CHARSET_SIZE = 26,
    parameter logic [7:0]  CHAR_BASE    = 8'h61
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [5:0]             start_len,
    input  logic                   stop,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [31:0]            a,
    output logic [31:0]            b,
    output logic [31:0]            c,
    output logic [31:0]            d,
    output logic [MD5_BLOCK_W-1:0] m,
`ifdef MD5GEN_CAND_INDEX_EN
    output logic [47:0]            cand_index,
`endif
    output logic                   busy,
    output logic                   done
);

    localparam logic [7:0] DigitMax = 8'(CHARSET_SIZE - 1);
    localparam logic [5:0] MaxLen   = 6'(MAX_LEN);

    md5_state_e                    state_q;
    logic [MAX_LEN-1:0][CHAR_W-1:0] digits_q, adv_digits, pad_digits;
    logic [5:0]                    cur_len_q, adv_len, pad_len, start_len_clamped;
    logic [MD5_BLOCK_W-1:0]        m_q, pad_block;
    logic                          valid_q, busy_q, done_q;
    logic                          xfer, last_beat, carry;
`ifdef MD5GEN_CAND_INDEX_EN
    logic [47:0]                   idx_q;
    assign cand_index = idx_q;
`endif

    assign a         = MD5_IV_A;
    assign b         = MD5_IV_B;
    assign c         = MD5_IV_C;
    assign d         = MD5_IV_D;
    assign m         = m_q;
    assign out_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign xfer      = valid_q && out_ready;

    // Clamp the requested first length into 1..MAX_LEN.
    always_comb begin
        start_len_clamped = start_len;
        if (start_len == 6'd0) begin
            start_len_clamped = 6'd1;
        end else if (start_len > MaxLen) begin
            start_len_clamped = MaxLen;
        end
    end

    // Odometer step: digit 0 counts first; a carry out of the top digit grows the length.
    always_comb begin
        adv_digits = digits_q;
        adv_len    = cur_len_q;
        carry      = 1'b1;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (carry && (i < int'(cur_len_q))) begin
                if (digits_q[i] == DigitMax) begin
                    adv_digits[i] = '0;
                end else begin
                    adv_digits[i] = digits_q[i] + 8'd1;
                    carry         = 1'b0;
                end
            end
        end
        if (carry) begin
            adv_len    = cur_len_q + 6'd1;
            adv_digits = '0;
        end
    end

    // Last candidate: full length with every digit at the top symbol.
    always_comb begin
        last_beat = (cur_len_q == MaxLen);
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (digits_q[i] != DigitMax) begin
                last_beat = 1'b0;
            end
        end
    end

    // Pad either the fresh start candidate or the successor of the current one.
    always_comb begin
        pad_digits = (state_q == RUN) ? adv_digits : '0;
        pad_len    = (state_q == RUN) ? adv_len : start_len_clamped;
    end

    md5_pad #(
        .MAX_LEN   (MAX_LEN),
        .CHAR_BASE (CHAR_BASE)
    ) u_pad (
        .digits_i (pad_digits),
        .len_i    (pad_len),
        .block_o  (pad_block)
    );

    // Control FSM with the odometer and registered block outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            m_q       <= '0;
            digits_q  <= '0;
            cur_len_q <= 6'd1;
`ifdef MD5GEN_CAND_INDEX_EN
            idx_q     <= '0;
`endif
        end else begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (stop) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                    end else if (start) begin
                        state_q   <= RUN;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        cur_len_q <= start_len_clamped;
                        digits_q  <= '0;
                        m_q       <= pad_block;
`ifdef MD5GEN_CAND_INDEX_EN
                        idx_q     <= '0;
`endif
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (xfer) begin
`ifdef MD5GEN_CAND_INDEX_EN
                        idx_q <= idx_q + 48'd1;
`endif
                        if (last_beat) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            digits_q  <= adv_digits;
                            cur_len_q <= adv_len;
                            m_q       <= pad_block;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md5_block_gen.sv
// Bench for md5_block_gen: a default instance (26 symbols, length 8) and a small
// instance (3 symbols, length 2) checked against a candidate-number model.
module tb_md5_block_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   start_v, stop_v, ready_v;
    logic [5:0]   slen_v [2];
    logic [1:0]   valid_v, busy_v, done_v;
    logic [31:0]  a_v [2], b_v [2], c_v [2], d_v [2];
    logic [511:0] m_v [2];
`ifdef MD5GEN_CAND_INDEX_EN
    logic [47:0]  idx_v [2];
`endif

    md5_block_gen u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_v[0]),
        .start_len  (slen_v[0]),
        .stop       (stop_v[0]),
        .out_ready  (ready_v[0]),
        .out_valid  (valid_v[0]),
        .a          (a_v[0]),
        .b          (b_v[0]),
        .c          (c_v[0]),
        .d          (d_v[0]),
        .m          (m_v[0]),
`ifdef MD5GEN_CAND_INDEX_EN
        .cand_index (idx_v[0]),
`endif
        .busy       (busy_v[0]),
        .done       (done_v[0])
    );

    md5_block_gen #(
        .MAX_LEN      (2),
        .CHARSET_SIZE (3),
        .CHAR_BASE    (8'h61)
    ) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_v[1]),
        .start_len  (slen_v[1]),
        .stop       (stop_v[1]),
        .out_ready  (ready_v[1]),
        .out_valid  (valid_v[1]),
        .a          (a_v[1]),
        .b          (b_v[1]),
        .c          (c_v[1]),
        .d          (d_v[1]),
        .m          (m_v[1]),
`ifdef MD5GEN_CAND_INDEX_EN
        .cand_index (idx_v[1]),
`endif
        .busy       (busy_v[1]),
        .done       (done_v[1])
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int nsym(input int u);
        return (u == 0) ? 26 : 3;
    endfunction

    function automatic int maxl(input int u);
        return (u == 0) ? 8 : 2;
    endfunction

    function automatic longint pow_n(input int n, input int e);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * n;
        return r;
    endfunction

    // Candidate number k of length len: base-n digits, least significant first.
    function automatic logic [511:0] exp_block(input int n, input int len, input longint k);
        logic [511:0] blk = '0;
        longint r = k;
        for (int i = 0; i < len; i++) begin
            blk[8*i +: 8] = 8'(64'h61 + 64'(r % n));
            r = r / n;
        end
        blk[8*len +: 8] = 8'h80;
        blk[511:448] = 64'(len * 8);
        return blk;
    endfunction

    // Model: each instance is either enumerating (len, k) or not.
    bit     md_run [2];
    bit     md_done [2];
    int     md_len [2];
    longint md_k [2];
    longint md_idx [2];

    always @(posedge clk or negedge rst_n) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                md_run[u] = 1'b0; md_done[u] = 1'b0; md_len[u] = 1; md_k[u] = 0; md_idx[u] = 0;
            end else if (md_run[u]) begin
                if (stop_v[u]) begin
                    md_run[u] = 1'b0;
                end else if (ready_v[u]) begin
                    if (md_len[u] == maxl(u) && md_k[u] == pow_n(nsym(u), md_len[u]) - 1) begin
                        md_run[u] = 1'b0;
                        md_done[u] = 1'b1;
                    end else begin
                        md_k[u]++;
                        md_idx[u]++;
                        if (md_k[u] == pow_n(nsym(u), md_len[u])) begin
                            md_len[u]++;
                            md_k[u] = 0;
                        end
                    end
                end
            end else if (stop_v[u]) begin
                md_done[u] = 1'b0;
            end else if (start_v[u]) begin
                md_run[u]  = 1'b1;
                md_done[u] = 1'b0;
                md_k[u]    = 0;
                md_idx[u]  = 0;
                if (slen_v[u] == 0) md_len[u] = 1;
                else if (int'(slen_v[u]) > maxl(u)) md_len[u] = maxl(u);
                else md_len[u] = int'(slen_v[u]);
            end
        end
    end

    // Cycle-by-cycle compare against the model.
    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            for (int u = 0; u < 2; u++) begin
                chk($sformatf("valid%0d", u), valid_v[u], md_run[u]);
                chk($sformatf("busy%0d", u), busy_v[u], md_run[u]);
                chk($sformatf("done%0d", u), done_v[u], md_done[u]);
                chk($sformatf("iv_a%0d", u), a_v[u], 32'h67452301);
                if (md_run[u]) begin
                    chk($sformatf("m%0d", u), m_v[u], exp_block(nsym(u), md_len[u], md_k[u]));
`ifdef MD5GEN_CAND_INDEX_EN
                    chk($sformatf("idx%0d", u), idx_v[u], 48'(md_idx[u]));
`endif
                end
            end
        end
    end

    logic [511:0] blk;
    int cnt;

    initial begin
        start_v = '0; stop_v = '0; ready_v = '0;
        slen_v[0] = 6'd1; slen_v[1] = 6'd1;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_v[0], 1'b0);
        chk("rst_busy", busy_v[0], 1'b0);
        chk("rst_done", done_v[0], 1'b0);
        chk("rst_m", m_v[0], '0);
        chk("rst_a", a_v[0], 32'h67452301);
        chk("rst_b", b_v[0], 32'hefcdab89);
        chk("rst_c", c_v[0], 32'h98badcfe);
        chk("rst_d", d_v[0], 32'h10325476);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // First block "a", latency 1.
        slen_v[0] = 6'd1; ready_v[0] = 1'b1; start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        blk = '0; blk[15:0] = 16'h8061; blk[455:448] = 8'h08;
        chk("beat1_m", m_v[0], blk);
        chk("beat1_valid", valid_v[0], 1'b1);

        // Run through the length-1 wrap; a start mid-run must be ignored.
        for (int n = 2; n <= 28; n++) begin
            if (n == 10) begin start_v[0] = 1'b1; slen_v[0] = 6'd5; end
            step();
            start_v[0] = 1'b0;
            if (n == 26) chk("beat26_byte0", m_v[0][7:0], 8'h7a);
            if (n == 27) begin
                chk("beat27_low", m_v[0][23:0], 24'h806161);
                chk("beat27_len", m_v[0][455:448], 8'h10);
            end
            if (n == 28) chk("beat28_low", m_v[0][15:0], 16'h6162);
        end

        // Backpressure: block held stable, nothing skipped.
        ready_v[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_m", m_v[0][23:0], 24'h806162);
            chk("hold_valid", valid_v[0], 1'b1);
        end
        ready_v[0] = 1'b1;
        step();
        chk("after_hold", m_v[0][23:0], 24'h806163);

        // Stop together with a transfer.
        stop_v[0] = 1'b1;
        step();
        stop_v[0] = 1'b0;
        chk("stop_valid", valid_v[0], 1'b0);
        chk("stop_busy", busy_v[0], 1'b0);

        slen_v[0] = 6'd3; start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        chk("len3_low", m_v[0][31:0], 32'h80616161);
        chk("len3_len", m_v[0][455:448], 8'h18);
`ifdef MD5GEN_CAND_INDEX_EN
        chk("idx0", idx_v[0], 48'd0);
        step();
        chk("idx1", idx_v[0], 48'd1);
        step();
        chk("idx2", idx_v[0], 48'd2);
`else
        step();
        step();
`endif
        chk("len3_third", m_v[0][31:0], 32'h80616163);

        // Start length clamping.
        stop_v[0] = 1'b1; step(); stop_v[0] = 1'b0;
        slen_v[0] = 6'd0; start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
        chk("clamp0", m_v[0][23:0], 24'h008061);
        stop_v[0] = 1'b1; step(); stop_v[0] = 1'b0;
        slen_v[0] = 6'd60; start_v[0] = 1'b1; step(); start_v[0] = 1'b0;
        chk("clamp60_low", m_v[0][79:0], 80'h0080_6161616161616161);
        chk("clamp60_len", m_v[0][455:448], 8'h40);
        stop_v[0] = 1'b1; step(); stop_v[0] = 1'b0;

        // Exhaust the small instance.
        slen_v[1] = 6'd1; ready_v[1] = 1'b1; start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        cnt = 0;
        blk = '0;
        for (int i = 0; i < 50 && valid_v[1]; i++) begin
            cnt++;
            blk = m_v[1];
            step();
        end
        chk("exh_count", 512'(cnt), 512'd12);
        chk("exh_last", blk[23:0], 24'h806363);
        chk("exh_valid", valid_v[1], 1'b0);
        chk("exh_done", done_v[1], 1'b1);
        start_v[1] = 1'b1;
        step();
        start_v[1] = 1'b0;
        chk("restart_m", m_v[1][23:0], 24'h008061);
        chk("restart_done", done_v[1], 1'b0);

        // Asynchronous reset mid-run on both instances.
        start_v[0] = 1'b1; slen_v[0] = 6'd2;
        step();
        start_v[0] = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("arst_valid", valid_v[u], 1'b0);
            chk("arst_busy", busy_v[u], 1'b0);
            chk("arst_done", done_v[u], 1'b0);
            chk("arst_m", m_v[u], '0);
`ifdef MD5GEN_CAND_INDEX_EN
            chk("arst_idx", idx_v[u], 48'd0);
`endif
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_arst_valid", valid_v[0], 1'b0);
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        chk("post_arst_m", m_v[0][23:0], 24'h806161);
        step();
        step();
        chk("post_arst_third", m_v[0][23:0], 24'h806163);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
